// File: rtl/dat_pkg.sv
// Shared definitions for the SD DAT-line receive path.
// Provides the CRC16 polynomial and width, the receiver FSM state
// encodings, the default bus/word widths and a single-bit CRC16 step.
package dat_pkg;

  localparam int              CRC_W    = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;

  localparam int N_DEF = 32;
  localparam int M_DEF = 4;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_DATA       = 3'd2;
  localparam logic [2:0] ST_CRC        = 3'd3;
  localparam logic [2:0] ST_END        = 3'd4;

  // One serial CRC16 step: the incoming bit is folded in at the MSB end.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                  input logic             d);
    logic fb;
    fb = d ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/dat_rx_m_n_crc16_lane.sv
// Serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT lane.
// Ports:
//   sd_clock  clock
//   reset     synchronous, active-high; clears the register
//   clear     zero the register (block arm)
//   enable    fold d into the CRC (data phase)
//   shift     shift the register left, zero fill (CRC compare phase)
//   d         lane data bit
//   crc_msb   current MSB, the next CRC bit expected on the line
module crc16_lane
  import dat_pkg::*;
(
  input  logic sd_clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic shift,
  input  logic d,
  output logic crc_msb
);

  logic [CRC_W-1:0] crc;

  always_ff @(posedge sd_clock) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc16_step(crc, d);
    end else if (shift) begin
      // Received CRC bits are only compared, never folded back in.
      crc <= {crc[CRC_W-2:0], 1'b0};
    end
  end

  assign crc_msb = crc[CRC_W-1];

endmodule

// File: rtl/dat_rx_m_n.sv
// SD DAT-line receiver: waits for an all-lanes-low start bit, deserialises
// m lanes per clock into n-bit words (MSB first), then checks one CRC16 per
// lane and the all-ones end bit after block_words words.
// Ports:
//   sd_clock    clock, posedge
//   reset       synchronous, active-high
//   enable      arm one block; sampled only in IDLE
//   p_m         DAT lanes, bit i = DAT[i]
//   p_n         assembled word, holds until the next word
//   word_valid  one-cycle pulse with each new p_n
//   complete    one-cycle pulse at the end of the block
//   crc_error   sticky per block, any lane CRC mismatch
//   end_error   sticky per block, end bit not all ones
//   timeout     one-cycle pulse, no start bit in time
//   busy        high in every state except IDLE
module dat_rx_m_n
  import dat_pkg::*;
#(
  parameter int n              = N_DEF,
  parameter int m              = M_DEF,
  parameter int block_words    = 128,
  parameter int timeout_cycles = 1024
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [m-1:0] p_m,
  output logic [n-1:0] p_n,
  output logic         word_valid,
  output logic         complete,
  output logic         crc_error,
  output logic         end_error,
  output logic         timeout,
  output logic         busy
);

  localparam int NIBS = n / m;
  localparam int NW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int WW   = $clog2(block_words + 1);
  localparam int TW   = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

  localparam logic [NW-1:0] NIB_LAST  = NW'(NIBS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(block_words - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(timeout_cycles - 1);

  logic [2:0]    state;
  logic [NW-1:0] nib_cnt;
  logic [WW-1:0] word_cnt;
  logic [TW-1:0] t_cnt;
  logic [3:0]    crc_cnt;
  logic [n-m-1:0] shreg;
  logic [m-1:0]  lane_msb;
  logic          arm;
  logic          crc_bad;

  assign arm     = (state == ST_IDLE) && enable;
  assign busy    = (state != ST_IDLE);
  assign crc_bad = |(p_m ^ lane_msb);

  for (genvar i = 0; i < m; i++) begin : g_lane
    crc16_lane u_crc (
      .sd_clock (sd_clock),
      .reset    (reset),
      .clear    (arm),
      .enable   (state == ST_DATA),
      .shift    (state == ST_CRC),
      .d        (p_m[i]),
      .crc_msb  (lane_msb[i])
    );
  end

  // Capture stage: the newest nibble is not stored here; it is joined
  // directly into p_n on the word-final cycle.
  always_ff @(posedge sd_clock) begin
    if (state == ST_DATA) begin
      shreg <= {shreg[n-2*m-1:0], p_m};
    end
  end

  // Control and word-output stage.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      p_n        <= '0;
      word_valid <= 1'b0;
      complete   <= 1'b0;
      crc_error  <= 1'b0;
      end_error  <= 1'b0;
      timeout    <= 1'b0;
      nib_cnt    <= '0;
      word_cnt   <= '0;
      t_cnt      <= '0;
      crc_cnt    <= '0;
    end else begin
      word_valid <= 1'b0;
      complete   <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state     <= ST_WAIT_START;
            crc_error <= 1'b0;
            end_error <= 1'b0;
            t_cnt     <= '0;
            word_cnt  <= '0;
            nib_cnt   <= '0;
          end
        end
        ST_WAIT_START: begin
          // Only all lanes low is a start bit; a partial low keeps counting.
          if (p_m == '0) begin
            state   <= ST_DATA;
            nib_cnt <= '0;
          end else if (t_cnt == T_LAST) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (nib_cnt == NIB_LAST) begin
            p_n        <= {shreg, p_m};
            word_valid <= 1'b1;
            nib_cnt    <= '0;
            word_cnt   <= word_cnt + 1'b1;
            if (word_cnt == WORD_LAST) begin
              state   <= ST_CRC;
              crc_cnt <= '0;
            end
          end else begin
            nib_cnt <= nib_cnt + 1'b1;
          end
        end
        ST_CRC: begin
          if (crc_bad) begin
            crc_error <= 1'b1;
          end
          if (crc_cnt == 4'd15) begin
            state <= ST_END;
          end else begin
            crc_cnt <= crc_cnt + 1'b1;
          end
        end
        ST_END: begin
          if (p_m != '1) begin
            end_error <= 1'b1;
          end
          complete <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dat_rx_m_n.sv
module tb_dat_rx_m_n;

  localparam int N     = 32;
  localparam int M     = 4;
  localparam int BW    = 2;
  localparam int TO    = 8;
  localparam int NIBS  = N / M;
  localparam int LBITS = BW * NIBS;

  logic         sd_clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [M-1:0] p_m;
  logic [N-1:0] p_n;
  logic         word_valid, complete, crc_error, end_error, timeout, busy;

  dat_rx_m_n #(.n(N), .m(M), .block_words(BW), .timeout_cycles(TO)) dut (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .enable     (enable),
    .p_m        (p_m),
    .p_n        (p_n),
    .word_valid (word_valid),
    .complete   (complete),
    .crc_error  (crc_error),
    .end_error  (end_error),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 sd_clock = ~sd_clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [M-1:0] stim[$];
  logic [N-1:0] got_w[$];
  logic         got_crc[$];
  logic         got_end[$];
  int           overlap;
  int           to_seen;

  task automatic clear_rec();
    got_w.delete();
    got_crc.delete();
    got_end.delete();
    overlap = 0;
    to_seen = 0;
  endtask

  task automatic step();
    @(posedge sd_clock);
    #1;
    if (word_valid) got_w.push_back(p_n);
    if (complete) begin
      got_crc.push_back(crc_error);
      got_end.push_back(end_error);
    end
    if (word_valid && complete) overlap++;
    if (timeout) to_seen++;
  endtask

  // Reference CRC: remainder of (lane bits * x^16) divided by the generator,
  // by plain long division over the augmented bit string.
  function automatic logic [15:0] model_crc(input logic [N-1:0] w[BW], input int lane);
    logic        bits[LBITS+16];
    logic [16:0] poly = 17'h11021;
    logic [15:0] r;
    for (int i = 0; i < LBITS + 16; i++) bits[i] = 1'b0;
    for (int j = 0; j < BW; j++)
      for (int k = 0; k < NIBS; k++)
        bits[j*NIBS+k] = w[j][N-M-M*k+lane];
    for (int i = 0; i < LBITS; i++)
      if (bits[i])
        for (int b = 0; b <= 16; b++) bits[i+b] = bits[i+b] ^ poly[16-b];
    for (int b = 0; b < 16; b++) r[15-b] = bits[LBITS+b];
    return r;
  endfunction

  task automatic add_block(input logic [N-1:0] w[BW], input int flip_lane,
                           input int flip_bit, input logic [M-1:0] endn);
    logic [15:0]  c[M];
    logic [M-1:0] nib;
    for (int i = 0; i < M; i++) c[i] = model_crc(w, i);
    if (flip_lane >= 0) c[flip_lane][flip_bit] = ~c[flip_lane][flip_bit];
    stim.push_back('0);
    for (int j = 0; j < BW; j++)
      for (int k = 0; k < NIBS; k++)
        stim.push_back(w[j][N-1-M*k -: M]);
    for (int b = 15; b >= 0; b--) begin
      for (int i = 0; i < M; i++) nib[i] = c[i][b];
      stim.push_back(nib);
    end
    stim.push_back(endn);
  endtask

  task automatic run(input bit hold);
    enable = 1'b1;
    p_m    = '1;
    step();
    if (!hold) enable = 1'b0;
    foreach (stim[i]) begin
      p_m = stim[i];
      step();
    end
    enable = 1'b0;
    p_m    = '1;
    repeat (3) step();
    stim.delete();
  endtask

  task automatic check_block(input string tag, input logic [N-1:0] w[BW],
                             input logic exp_crc, input logic exp_end);
    check({tag, "_nwords"}, got_w.size(), BW);
    for (int j = 0; j < BW && j < got_w.size(); j++)
      check($sformatf("%s_word%0d", tag, j), got_w[j], w[j]);
    check({tag, "_ncomplete"}, got_crc.size(), 1);
    if (got_crc.size() > 0) begin
      check({tag, "_crc_err"}, got_crc[0], exp_crc);
      check({tag, "_end_err"}, got_end[0], exp_end);
    end
    check({tag, "_overlap"}, overlap, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p_n"}, p_n, 0);
    check({tag, "_flags"}, {word_valid, complete, crc_error, end_error, timeout, busy}, 6'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] w[BW];
    logic [N-1:0] w2[BW];
    int           tcyc;
    int           fl, fb;
    logic [M-1:0] en;

    reset  = 1'b1;
    enable = 1'b0;
    p_m    = '1;
    clear_rec();
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Clean reference block
    w[0] = 32'h12345678;
    w[1] = 32'h9ABCDEF0;
    clear_rec();
    add_block(w, -1, 0, 4'hF);
    run(0);
    check_block("clean", w, 1'b0, 1'b0);
    check("clean_idle_busy", busy, 1'b0);

    // CRC bit 7 of lane 2 inverted
    clear_rec();
    add_block(w, 2, 7, 4'hF);
    run(0);
    check_block("crcflip", w, 1'b1, 1'b0);
    check("crcflip_sticky", crc_error, 1'b1);

    // Bad end bit
    clear_rec();
    add_block(w, -1, 0, 4'b1011);
    run(0);
    check_block("endbad", w, 1'b0, 1'b1);

    // Start-bit timeout with a partial-low glitch
    clear_rec();
    enable = 1'b1;
    p_m    = '1;
    step();
    enable = 1'b0;
    tcyc   = -1;
    for (int c = 1; c <= 20; c++) begin
      p_m = (c == 3) ? 4'b1110 : 4'hF;
      step();
      if (c == 7) check("to_busy_before", busy, 1'b1);
      if (timeout && tcyc < 0) tcyc = c;
    end
    check("to_cycle", tcyc, TO);
    check("to_pulses", to_seen, 1);
    check("to_busy_after", busy, 1'b0);
    check("to_no_words", got_w.size(), 0);

    // Reset after 5 data nibbles, then a clean block
    clear_rec();
    add_block(w, -1, 0, 4'hF);
    enable = 1'b1;
    p_m    = '1;
    step();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      p_m = stim[i];
      step();
    end
    reset = 1'b1;
    p_m   = stim[6];
    step();
    check_all_zero("midreset");
    reset = 1'b0;
    p_m   = '1;
    repeat (3) step();
    check("midreset_no_complete", got_crc.size(), 0);
    stim.delete();
    clear_rec();
    w2[0] = 32'h12345678;
    w2[1] = $urandom;
    add_block(w2, -1, 0, 4'hF);
    run(0);
    check_block("after_reset", w2, 1'b0, 1'b0);

    // Back-to-back with enable held: block 1 bad CRC, block 2 clean
    clear_rec();
    w[0]  = $urandom;
    w[1]  = $urandom;
    w2[0] = $urandom;
    w2[1] = $urandom;
    add_block(w, $urandom_range(0, M - 1), $urandom_range(0, 15), 4'hF);
    stim.push_back(4'hF);
    add_block(w2, -1, 0, 4'hF);
    run(1);
    check("b2b_ncomplete", got_crc.size(), 2);
    check("b2b_nwords", got_w.size(), 2 * BW);
    if (got_crc.size() == 2) begin
      check("b2b_blk1_crc", got_crc[0], 1'b1);
      check("b2b_blk2_crc", got_crc[1], 1'b0);
      check("b2b_blk2_end", got_end[1], 1'b0);
    end
    if (got_w.size() == 2 * BW) begin
      for (int j = 0; j < BW; j++) begin
        check($sformatf("b2b_w1_%0d", j), got_w[j], w[j]);
        check($sformatf("b2b_w2_%0d", j), got_w[BW+j], w2[j]);
      end
    end

    // Randomized blocks with optional CRC and end-bit faults
    for (int t = 0; t < 20; t++) begin
      clear_rec();
      for (int j = 0; j < BW; j++) w[j] = $urandom;
      fl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, M - 1)) : -1;
      fb = $urandom_range(0, 15);
      en = ($urandom_range(0, 2) == 0) ? M'($urandom_range(0, 14)) : 4'hF;
      add_block(w, fl, fb, en);
      run(0);
      check_block($sformatf("rnd%0d", t), w, fl >= 0, en != 4'hF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
